// File: rtl/spi_dev_rx.sv
// Device-end receiver for the strobe/clock/data serial link: oversamples all three
// lines, rebuilds bytes framed by an active-low strobe and presents them on a valid/ack register.
module spi_dev_rx #(
  parameter int LSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dev_stb,
  input  logic       dev_clk,
  input  logic       dev_dio,
  output logic [7:0] data,
  output logic       data_rdy,
  input  logic       data_ack,
  output logic [2:0] byte_idx,
  output logic       frame_start,
  output logic       frame_end,
  output logic       overrun,
  output logic       frame_err,
  input  logic       err_clr,
  output logic [1:0] diag_state,
  output logic [2:0] diag_bit_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RECV = 2'b01,
    ERR  = 2'b10
  } state_t;

  logic [SYNC_STAGES-1:0] stb_sync_q, stb_sync_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dio_sync_q, dio_sync_d;
  logic stb_dly_q, stb_dly_d;
  logic clk_dly_q, clk_dly_d;
  logic stb_fall_q, stb_fall_d;
  logic stb_rise_q, stb_rise_d;
  logic clk_rise_q, clk_rise_d;
  logic dio_smp_q, dio_smp_d;
  logic stb_s, clk_s, dio_s;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] fbc_q, fbc_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       rdy_q, rdy_d;
  logic [2:0] idx_q, idx_d;
  logic       fs_q, fs_d;
  logic       fe_q, fe_d;
  logic       ovr_q, ovr_d;
  logic       ferr_q, ferr_d;
  logic [7:0] shifted;

  // Edge events are registered, so the FSM always sees one-cycle pulses with dio aligned to them.
  always_comb begin
    stb_sync_d = {stb_sync_q[SYNC_STAGES-2:0], dev_stb};
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], dev_clk};
    dio_sync_d = {dio_sync_q[SYNC_STAGES-2:0], dev_dio};
    stb_s      = stb_sync_q[SYNC_STAGES-1];
    clk_s      = clk_sync_q[SYNC_STAGES-1];
    dio_s      = dio_sync_q[SYNC_STAGES-1];
    stb_dly_d  = stb_s;
    clk_dly_d  = clk_s;
    stb_fall_d = stb_dly_q & ~stb_s;
    stb_rise_d = ~stb_dly_q & stb_s;
    clk_rise_d = ~clk_dly_q & clk_s;
    dio_smp_d  = dio_s;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stb_sync_q <= '1;
      clk_sync_q <= '1;
      dio_sync_q <= '0;
      stb_dly_q  <= 1'b1;
      clk_dly_q  <= 1'b1;
      stb_fall_q <= 1'b0;
      stb_rise_q <= 1'b0;
      clk_rise_q <= 1'b0;
      dio_smp_q  <= 1'b0;
    end else begin
      stb_sync_q <= stb_sync_d;
      clk_sync_q <= clk_sync_d;
      dio_sync_q <= dio_sync_d;
      stb_dly_q  <= stb_dly_d;
      clk_dly_q  <= clk_dly_d;
      stb_fall_q <= stb_fall_d;
      stb_rise_q <= stb_rise_d;
      clk_rise_q <= clk_rise_d;
      dio_smp_q  <= dio_smp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    fbc_d     = fbc_q;
    shift_d   = shift_q;
    data_d    = data_q;
    rdy_d     = rdy_q;
    idx_d     = idx_q;
    fs_d      = 1'b0;
    fe_d      = 1'b0;
    ovr_d     = ovr_q;
    ferr_d    = ferr_q;
    shifted   = (LSB_FIRST != 0) ? {dio_smp_q, shift_q[7:1]} : {shift_q[6:0], dio_smp_q};

    if (data_ack && rdy_q) rdy_d = 1'b0;
    // Clear first so a same-cycle set event below takes priority.
    if (err_clr) begin
      ovr_d  = 1'b0;
      ferr_d = 1'b0;
    end

    case (state_q)
      RECV: begin
        if (stb_rise_q) begin
          fe_d      = 1'b1;
          state_d   = IDLE;
          bit_cnt_d = 3'd0;
          shift_d   = 8'd0;
          if (bit_cnt_q != 3'd0) ferr_d = 1'b1;
        end else if (clk_rise_q) begin
          shift_d = shifted;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            if (!rdy_q || data_ack) begin
              data_d = shifted;
              idx_d  = fbc_q;
              rdy_d  = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
            if (fbc_q != 3'd7) fbc_d = fbc_q + 3'd1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: begin
        // IDLE, and the reserved ERR code which behaves as IDLE.
        if (stb_fall_q) begin
          fs_d      = 1'b1;
          bit_cnt_d = 3'd0;
          fbc_d     = 3'd0;
          state_d   = RECV;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      fbc_q     <= 3'd0;
      shift_q   <= 8'd0;
      data_q    <= 8'd0;
      rdy_q     <= 1'b0;
      idx_q     <= 3'd0;
      fs_q      <= 1'b0;
      fe_q      <= 1'b0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      fbc_q     <= fbc_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      rdy_q     <= rdy_d;
      idx_q     <= idx_d;
      fs_q      <= fs_d;
      fe_q      <= fe_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign data         = data_q;
  assign data_rdy     = rdy_q;
  assign byte_idx     = idx_q;
  assign frame_start  = fs_q;
  assign frame_end    = fe_q;
  assign overrun      = ovr_q;
  assign frame_err    = ferr_q;
  assign diag_state   = state_q;
  assign diag_bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_spi_dev_rx.sv
// Directed bench for spi_dev_rx: LSB-first instance for framing/ack/error cases,
// plus an MSB-first instance for bit order and reset behaviour.
module tb_spi_dev_rx;

  logic clk = 1'b0;
  logic rst, dev_stb, dev_clk, dev_dio, err_clr, man_ack, auto_ack;

  logic [7:0] data, data_m;
  logic       data_rdy, data_rdy_m, data_ack, data_ack_m;
  logic [2:0] byte_idx, byte_idx_m;
  logic       frame_start, frame_start_m, frame_end, frame_end_m;
  logic       overrun, overrun_m, frame_err, frame_err_m;
  logic [1:0] diag_state, diag_state_m;
  logic [2:0] diag_bit_cnt, diag_bit_cnt_m;

  int vectors = 0;
  int miscompares = 0;
  int fs_cnt = 0, fe_cnt = 0, acc_cnt = 0, rdy_hi_cnt = 0;
  logic [7:0] log_data [64];
  logic [2:0] log_idx [64];

  always #5 clk = ~clk;

  assign data_ack   = (auto_ack & data_rdy) | man_ack;
  assign data_ack_m = (auto_ack & data_rdy_m) | man_ack;

  spi_dev_rx #(.LSB_FIRST(1), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .dev_stb(dev_stb), .dev_clk(dev_clk), .dev_dio(dev_dio),
    .data(data), .data_rdy(data_rdy), .data_ack(data_ack), .byte_idx(byte_idx),
    .frame_start(frame_start), .frame_end(frame_end), .overrun(overrun),
    .frame_err(frame_err), .err_clr(err_clr), .diag_state(diag_state),
    .diag_bit_cnt(diag_bit_cnt)
  );

  spi_dev_rx #(.LSB_FIRST(0), .SYNC_STAGES(2)) dut_m (
    .clk(clk), .rst(rst), .dev_stb(dev_stb), .dev_clk(dev_clk), .dev_dio(dev_dio),
    .data(data_m), .data_rdy(data_rdy_m), .data_ack(data_ack_m), .byte_idx(byte_idx_m),
    .frame_start(frame_start_m), .frame_end(frame_end_m), .overrun(overrun_m),
    .frame_err(frame_err_m), .err_clr(err_clr), .diag_state(diag_state_m),
    .diag_bit_cnt(diag_bit_cnt_m)
  );

  // Event log for the LSB-first instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_start) fs_cnt <= fs_cnt + 1;
    if (frame_end) fe_cnt <= fe_cnt + 1;
    if (data_rdy) rdy_hi_cnt <= rdy_hi_cnt + 1;
    if (data_rdy && data_ack && acc_cnt < 64) begin
      log_data[acc_cnt] <= data;
      log_idx[acc_cnt]  <= byte_idx;
      acc_cnt <= acc_cnt + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic ack_here);
    dev_dio = b;
    dev_clk = 1'b0;
    tick(4);
    dev_clk = 1'b1;
    if (ack_here) begin
      tick(3);
      man_ack = 1'b1;
      tick(1);
      man_ack = 1'b0;
    end else begin
      tick(4);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic msb_first, input logic ack_last);
    for (int i = 0; i < 8; i++)
      send_bit(msb_first ? b[7-i] : b[i], ack_last && (i == 7));
  endtask

  task automatic stb_low();
    dev_stb = 1'b0;
    tick(6);
  endtask

  task automatic stb_high();
    dev_stb = 1'b1;
    tick(10);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_data"}, data, 8'h00);
    chk({tag, "_rdy"}, data_rdy, 1'b0);
    chk({tag, "_idx"}, byte_idx, 3'd0);
    chk({tag, "_fs"}, frame_start, 1'b0);
    chk({tag, "_fe"}, frame_end, 1'b0);
    chk({tag, "_ovr"}, overrun, 1'b0);
    chk({tag, "_ferr"}, frame_err, 1'b0);
    chk({tag, "_state"}, diag_state, 2'b00);
    chk({tag, "_bitcnt"}, diag_bit_cnt, 3'd0);
  endtask

  int b_fs, b_fe, b_acc, b_hi;

  task automatic snap();
    b_fs  = fs_cnt;
    b_fe  = fe_cnt;
    b_acc = acc_cnt;
    b_hi  = rdy_hi_cnt;
  endtask

  initial begin
    rst = 1'b0; dev_stb = 1'b1; dev_clk = 1'b1; dev_dio = 1'b0;
    err_clr = 1'b0; man_ack = 1'b0; auto_ack = 1'b0;
    tick(3);
    chk_reset_vals("rst");
    rst = 1'b1;
    tick(3);

    // Single byte 0x01, acked as soon as it appears.
    snap();
    auto_ack = 1'b1;
    stb_low();
    send_byte(8'h01, 1'b0, 1'b0);
    stb_high();
    chk("t1_fs", fs_cnt - b_fs, 1);
    chk("t1_fe", fe_cnt - b_fe, 1);
    chk("t1_events", acc_cnt - b_acc, 1);
    chk("t1_rdy_cycles", rdy_hi_cnt - b_hi, 1);
    chk("t1_data", log_data[b_acc], 8'h01);
    chk("t1_idx", log_idx[b_acc], 3'd0);
    chk("t1_ovr", overrun, 1'b0);
    chk("t1_ferr", frame_err, 1'b0);
    chk("t1_rdy_after", data_rdy, 1'b0);

    // Three bytes in one frame.
    snap();
    stb_low();
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h04, 1'b0, 1'b0);
    send_byte(8'h08, 1'b0, 1'b0);
    stb_high();
    chk("t2_fs", fs_cnt - b_fs, 1);
    chk("t2_fe", fe_cnt - b_fe, 1);
    chk("t2_events", acc_cnt - b_acc, 3);
    chk("t2_data0", log_data[b_acc], 8'h02);
    chk("t2_data1", log_data[b_acc+1], 8'h04);
    chk("t2_data2", log_data[b_acc+2], 8'h08);
    chk("t2_idx0", log_idx[b_acc], 3'd0);
    chk("t2_idx1", log_idx[b_acc+1], 3'd1);
    chk("t2_idx2", log_idx[b_acc+2], 3'd2);

    // Overrun: second byte arrives with the first still unacknowledged.
    auto_ack = 1'b0;
    stb_low();
    send_byte(8'h55, 1'b0, 1'b0);
    send_byte(8'hAA, 1'b0, 1'b0);
    stb_high();
    chk("t3_data", data, 8'h55);
    chk("t3_rdy", data_rdy, 1'b1);
    chk("t3_idx", byte_idx, 3'd0);
    chk("t3_ovr", overrun, 1'b1);
    chk("t3_ferr", frame_err, 1'b0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
    chk("t3_ovr_clr", overrun, 1'b0);
    chk("t3_rdy_kept", data_rdy, 1'b1);
    man_ack = 1'b1;
    tick(1);
    man_ack = 1'b0;
    tick(1);
    chk("t3_rdy_acked", data_rdy, 1'b0);

    // Ack lands in the very cycle the second byte completes.
    stb_low();
    send_byte(8'h55, 1'b0, 1'b0);
    send_byte(8'hAA, 1'b0, 1'b1);
    stb_high();
    chk("t4_data", data, 8'hAA);
    chk("t4_rdy", data_rdy, 1'b1);
    chk("t4_idx", byte_idx, 3'd1);
    chk("t4_ovr", overrun, 1'b0);
    man_ack = 1'b1;
    tick(1);
    man_ack = 1'b0;
    tick(1);
    chk("t4_rdy_acked", data_rdy, 1'b0);

    // Strobe released after five bits, then a clean frame.
    snap();
    stb_low();
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    stb_high();
    chk("t5_ferr", frame_err, 1'b1);
    chk("t5_rdy", data_rdy, 1'b0);
    chk("t5_no_rdy_cycles", rdy_hi_cnt - b_hi, 0);
    chk("t5_fe", fe_cnt - b_fe, 1);
    chk("t5_state", diag_state, 2'b00);
    chk("t5_bitcnt", diag_bit_cnt, 3'd0);
    snap();
    auto_ack = 1'b1;
    stb_low();
    send_byte(8'h3C, 1'b0, 1'b0);
    stb_high();
    chk("t5_clean_events", acc_cnt - b_acc, 1);
    chk("t5_clean_data", log_data[b_acc], 8'h3C);
    chk("t5_clean_idx", log_idx[b_acc], 3'd0);
    chk("t5_ferr_sticky", frame_err, 1'b1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
    chk("t5_ferr_clr", frame_err, 1'b0);

    // MSB-first byte on the second instance, after a clean reset.
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(3);
    stb_low();
    chk("t6_msb_state", diag_state_m, 2'b01);
    send_byte(8'hA5, 1'b1, 1'b0);
    stb_high();
    chk("t6_msb_data", data_m, 8'hA5);
    chk("t6_msb_rdy", data_rdy_m, 1'b0);
    chk("t6_lsb_data", data, 8'hA5);

    // Reset mid-byte, then dev_clk toggling with the strobe idle.
    snap();
    stb_low();
    send_byte(8'hF0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    chk("t6_pre_bitcnt", diag_bit_cnt, 3'd3);
    rst = 1'b0;
    #1;
    chk_reset_vals("t6_async");
    chk("t6_async_m_data", data_m, 8'h00);
    chk("t6_async_m_state", diag_state_m, 2'b00);
    dev_stb = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(4);
    for (int i = 0; i < 8; i++) send_bit(i[0], 1'b0);
    tick(6);
    chk_reset_vals("t6_after");
    chk("t6_m_rdy", data_rdy_m, 1'b0);
    chk("t6_m_data", data_m, 8'h00);
    chk("t6_no_fs", fs_cnt - b_fs, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_dev_rx.md
Name: spi_dev_rx

Overview:
Device-end receiver for the 3-wire strobe/clock/data serial link driven by our SPI byte initiator (dev_stb, dev_clk, dev_dio). It oversamples all three lines in the system clock domain and reconstructs bytes framed by an active-low strobe. Each byte is presented on a valid/ack holding register. The block also reports frame boundaries, the byte index within a frame, sticky overrun and framing errors, and diagnostic state. It is used as a loopback checker and as the model of the display/driver end in FPGA self-tests.

Parameters:
LSB_FIRST, 1, 1 = first serial bit lands in data[0]; 0 = first bit lands in data[7]
SYNC_STAGES, 2, synchronizer flops per input line (minimum 2)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset
dev_stb  in  1  frame select, active low; idle high
dev_clk  in  1  serial clock, idle high; data sampled on its rising edge
dev_dio  in  1  serial data
data  out  8  last received byte
data_rdy  out  1  data valid; held until acknowledged
data_ack  in  1  consumer accepts data in a cycle where data_rdy=1
byte_idx  out  3  position of the presented byte within its frame (0 = first), saturates at 7
frame_start  out  1  one-cycle pulse on synchronized dev_stb falling edge
frame_end  out  1  one-cycle pulse on synchronized dev_stb rising edge
overrun  out  1  sticky: a byte completed while the holding register was full
frame_err  out  1  sticky: strobe released mid-byte
err_clr  in  1  clears overrun and frame_err
diag_state  out  2  FSM state
diag_bit_cnt  out  3  bits shifted in the current byte

Behaviour:
- Reset (rst=0, async): data=0, data_rdy=0, byte_idx=0, frame_start=0, frame_end=0, overrun=0, frame_err=0, state=IDLE, bit_cnt=0, shift register=0.
- Synchronizer reset values are stb=1, clk=1, dio=0, so no false edge is seen on reset release.
- Edge detection uses the synchronized lines plus one delay flop per line.
- Timing requirement: each dev_clk high and low phase must last at least SYNC_STAGES+1 clk cycles. Faster input is out of spec and gives undefined results.
- States (diag_state encoding):
  - IDLE=00: wait for stb fall. On stb fall: pulse frame_start, bit_cnt=0, frame byte counter=0, go to RECV.
  - RECV=01, on a dev_clk rising edge:
    - Shift in dio: right-shift into bit 7 when LSB_FIRST=1, left-shift into bit 0 when LSB_FIRST=0.
    - Increment bit_cnt. On the 8th bit, bit_cnt wraps to 0 and the byte completes.
  - RECV=01, on stb rise:
    - Pulse frame_end and go to IDLE.
    - If bit_cnt!=0: set frame_err and discard the partial byte.
  - ERR=10: reserved. Not entered by this revision; decodes as IDLE.
- dev_clk edges while stb is high are ignored.
- If stb rises and a clk edge occur in the same cycle, stb wins: the bit is not shifted.
- Byte completion, in the same cycle as the 8th rising edge is detected:
  - If data_rdy=0, or data_ack=1 in that cycle: load data, load byte_idx from the frame byte counter, set data_rdy=1 on the next edge.
  - Otherwise: drop the new byte, keep data, set overrun.
  - The frame byte counter increments on every completed byte, dropped ones included, and saturates at 7.
- Latency: data_rdy rises SYNC_STAGES+2 clk edges after the first clk edge that samples dev_clk high for the 8th bit.
- data_ack with data_rdy=1 clears data_rdy on the next edge. data_ack with data_rdy=0 is ignored.
- Sticky flags: err_clr clears overrun and frame_err. If a set event and err_clr occur in the same cycle, the set wins.
- Rapid strobe: a stb rise followed by a stb fall (at least two cycles apart) produces frame_end, then frame_start, and a new frame.
- Reset asserted mid-byte discards all state. Reception restarts only after a fresh stb fall.

Test Plan:
1. Default params; frame with one byte 0x01 sent LSB-first; ack immediately -> frame_start pulse, data=0x01, data_rdy=1 for one cycle, byte_idx=0, frame_end pulse, overrun=0, frame_err=0.
2. One frame with bytes 0x02, 0x04, 0x08, each acked -> three data_rdy events with data 0x02/0x04/0x08 and byte_idx 0/1/2; one frame_start and one frame_end.
3. Frame with bytes 0x55 then 0xAA, no ack -> data stays 0x55, data_rdy=1, overrun=1. Assert err_clr -> overrun=0. Ack -> data_rdy=0.
4. Ack asserted in the same cycle the 2nd byte completes -> data becomes 0xAA, data_rdy stays 1, overrun=0.
5. Strobe released after 5 bits -> frame_err=1, data_rdy stays 0, frame_end pulses. A following clean 0x3C frame is received correctly.
6. LSB_FIRST=0, byte 0xA5 -> data=0xA5. Reset pulsed mid-byte and dev_clk toggled with stb high -> no data_rdy; all outputs at reset values.
